// File: rtl/rv32_pkg.sv
// RV32I encoding constants shared by the instruction encoder and its bench:
// format codes, base opcodes, the canonical NOP and an immediate-fit helper.
package rv32_pkg;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} slot_e;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP = {12'd0, 5'd0, 3'd0, 5'd0, OP_IMM};

  // True when v is a sign-extension of its low n bits (bits [31:n-1] all equal).
  function automatic logic fits_signed(input logic [31:0] v, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ((i >= n - 1) && (v[i] != v[31])) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: decoded fields -> RV32I word plus error flag.
// Immediate range checking is compiled in with INSTR_ENC_RANGE_CHECK_EN.
module instr_pack
  import rv32_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_instr,
  output logic        o_err
);

  logic w_rng_bad;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // B and J offsets are in half-words, so an odd value cannot be encoded.
  always_comb begin
    w_rng_bad = 1'b0;
    case (i_fmt)
      FMT_I, FMT_S: w_rng_bad = !fits_signed(i_imm, 12);
      FMT_B:        w_rng_bad = !fits_signed(i_imm, 13) || i_imm[0];
      FMT_J:        w_rng_bad = !fits_signed(i_imm, 21) || i_imm[0];
      FMT_U:        w_rng_bad = (i_imm[11:0] != 12'd0);
      default:      w_rng_bad = 1'b0;
    endcase
  end
`else
  assign w_rng_bad = 1'b0;
`endif

  always_comb begin
    o_instr = NOP;
    o_err   = 1'b0;
    case (i_fmt)
      FMT_R: o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      FMT_S: o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      FMT_B: o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                        i_imm[4:1], i_imm[11], i_opcode};
      FMT_U: o_instr = {i_imm[31:12], i_rd, i_opcode};
      FMT_J: o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      default: begin
        o_instr = NOP;
        o_err   = 1'b1;
      end
    endcase
    if (w_rng_bad) begin
      o_err = 1'b1;
    end else begin
      o_err = o_err;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder with a one-entry output slot and a
// word-address counter. Optional immediate range check: INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
  import rv32_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in
);

  slot_e             r_state;
  logic [31:0]       r_instr;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       w_instr;
  logic              w_err;
  logic              w_in_hs;
  logic              w_out_hs;

  instr_pack u_pack (
    .i_fmt    (in_fmt),
    .i_opcode (in_opcode),
    .i_rd     (in_rd),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .i_funct3 (in_funct3),
    .i_funct7 (in_funct7),
    .i_imm    (in_imm),
    .o_instr  (w_instr),
    .o_err    (w_err)
  );

  assign out_valid = (r_state == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;
  assign out_instr = r_instr;
  assign out_err   = r_err;
  assign out_addr  = r_addr;

  // Output slot and address counter; an explicit load overrides the post-handshake increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_instr <= 32'd0;
      r_err   <= 1'b0;
      r_addr  <= ADDR_W'(RESET_ADDR);
    end else begin
      if (w_in_hs) begin
        r_state <= ST_FULL;
        r_instr <= w_instr;
        r_err   <= w_err;
      end else if (w_out_hs) begin
        r_state <= ST_EMPTY;
      end
      if (addr_load) begin
        r_addr <= addr_in;
      end else if (w_out_hs) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

endmodule
